// File: rtl/prio_enc_rr_sched.sv
// Round-robin scheduler over four request channels plus an 8-bit priority encoder.
// Latency: one cycle from request to registered result (S/F/out_valid) and ack pulse.
// Backpressure: a held result stays frozen while out_ready=0; acceptance and reload share one edge.
//
// Ports:
//   clk, rst_n      - single rising-edge clock, asynchronous active-low reset
//   I0..I3          - 8-bit request data vectors of channels 0..3
//   req             - per-channel request, bit k for channel k
//   ack             - one-hot, one-cycle grant pulse aligned with the first cycle of a result
//   S               - index of the channel whose result is held
//   F               - index of the highest set bit of the granted vector (bit 7 = code 7)
//   out_valid       - S/F hold a result
//   out_ready       - consumer accepts the held result
//   lock            - keep granting the current S channel while it keeps requesting
//   zero            - (only with PRIO_ENC_ZERO_DETECT_EN) granted vector was all zero
//
// Optional feature macro: PRIO_ENC_ZERO_DETECT_EN adds the registered 'zero' output.
// Without it, an all-zero vector encodes to F=0, indistinguishable from bit 0 set.

module prio_enc_rr_sched #(
  parameter int PTR_INIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] I0,
  input  logic [7:0] I1,
  input  logic [7:0] I2,
  input  logic [7:0] I3,
  input  logic [3:0] req,
  output logic [3:0] ack,
  output logic [1:0] S,
  output logic [2:0] F,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic       lock
`ifdef PRIO_ENC_ZERO_DETECT_EN
  ,
  output logic       zero
`endif
);

  localparam logic [1:0] PTR_RST = 2'(PTR_INIT);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] s_d;
  logic [2:0] f_d;
  logic [3:0] ack_d;

  logic       accept;
  logic       load;
  logic       lock_hit;
  logic [1:0] scan_base;
  logic [1:0] win;
  logic [7:0] win_vec;

  // First requesting channel scanning base, base+1, ... with 2-bit wraparound.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    logic       found;
    rr_pick = base;
    found   = 1'b0;
    for (int off = 0; off < 4; off++) begin
      idx = base + 2'(off);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // Index of the highest set bit; ascending scan so the last hit (highest) wins.
  function automatic logic [2:0] enc8(input logic [7:0] v);
    enc8 = 3'd0;
    for (int b = 0; b < 8; b++) begin
      if (v[b]) enc8 = 3'(b);
    end
  endfunction

  // An accepted result moves the scan start past the channel just served,
  // in the same edge that picks the next winner.
  assign accept    = (state_q == HOLD) && out_ready;
  assign scan_base = accept ? (S + 2'd1) : ptr_q;
  assign lock_hit  = lock && req[S];
  assign win       = lock_hit ? S : rr_pick(req, scan_base);

  always_comb begin
    win_vec = I0;
    case (win)
      2'd0: win_vec = I0;
      2'd1: win_vec = I1;
      2'd2: win_vec = I2;
      2'd3: win_vec = I3;
      default: win_vec = I0;
    endcase
  end

  // Next-state / next-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    s_d     = S;
    f_d     = F;
    ack_d   = 4'b0000;
    load    = 1'b0;

    if (accept) ptr_d = S + 2'd1;

    case (state_q)
      IDLE: begin
        if (req != 4'b0000) load = 1'b1;
      end
      HOLD: begin
        if (out_ready) begin
          if (req != 4'b0000) load = 1'b1;
          else                state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d = HOLD;
      s_d     = win;
      f_d     = enc8(win_vec);
      ack_d   = 4'b0001 << win;
      // A locked grant does not consume a round-robin turn.
      if (lock_hit) ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      S       <= 2'd0;
      F       <= 3'd0;
      ack     <= 4'b0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      S       <= s_d;
      F       <= f_d;
      ack     <= ack_d;
    end
  end

  assign out_valid = (state_q == HOLD);

`ifdef PRIO_ENC_ZERO_DETECT_EN
  // Tracks F timing: only updated on a loading edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero <= 1'b0;
    end else if (load) begin
      zero <= (win_vec == 8'h00);
    end
  end
`endif

endmodule

// File: tb/tb_prio_enc_rr_sched.sv
// Testbench for prio_enc_rr_sched: directed scenarios followed by randomized
// traffic, all compared against a transaction-level reference model.
module tb_prio_enc_rr_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din [4];
  logic [3:0] req;
  logic       out_ready;
  logic       lock;
  wire  [3:0] ack;
  wire  [1:0] S;
  wire  [2:0] F;
  wire        out_valid;
`ifdef PRIO_ENC_ZERO_DETECT_EN
  wire        zero;
`endif

  always #5 clk = ~clk;

  prio_enc_rr_sched #(.PTR_INIT(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .I0        (din[0]),
    .I1        (din[1]),
    .I2        (din[2]),
    .I3        (din[3]),
    .req       (req),
    .ack       (ack),
    .S         (S),
    .F         (F),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lock      (lock)
`ifdef PRIO_ENC_ZERO_DETECT_EN
    ,
    .zero      (zero)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: what the consumer should see.
  bit         m_valid;
  int         m_s, m_f, m_ptr;
  logic [3:0] m_ack;
  bit         m_zero;

  task automatic model_reset();
    m_valid = 0; m_s = 0; m_f = 0; m_ptr = 0; m_ack = 4'b0000; m_zero = 0;
  endtask

  // Apply one clock edge worth of scheduling rules to the model.
  task automatic model_edge();
    bit accept, can_load, hit;
    int base, w;
    accept   = m_valid && out_ready;
    can_load = (!m_valid || out_ready) && (req != 4'b0000);
    m_ack    = 4'b0000;
    if (can_load) begin
      hit  = lock && req[m_s];
      base = accept ? (m_s + 1) % 4 : m_ptr;
      w    = -1;
      if (hit) w = m_s;
      else begin
        for (int k = 0; k < 4; k++)
          if (w < 0 && req[(base + k) % 4]) w = (base + k) % 4;
        m_ptr = base;
      end
      m_s = w;
      m_f = 0;
      for (int b = 7; b >= 0; b--)
        if (m_f == 0 && din[w][b]) m_f = b;
      m_zero  = (din[w] == 8'h00);
      m_valid = 1;
      m_ack   = 4'b0001 << w;
    end else if (accept) begin
      m_ptr   = (m_s + 1) % 4;
      m_valid = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".S"},     32'(S),         32'(m_s));
    chk({tag, ".F"},     32'(F),         32'(m_f));
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".ack"},   32'(ack),       32'(m_ack));
    chk({tag, ".onehot"}, 32'($onehot0(ack)), 32'd1);
`ifdef PRIO_ENC_ZERO_DETECT_EN
    chk({tag, ".zero"},  32'(zero),      32'(m_zero));
`endif
  endtask

  task automatic step(input logic [3:0] r, input bit ordy, input bit lk, input string tag);
    req = r; out_ready = ordy; lock = lk;
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; req = 4'b0000; out_ready = 1'b0; lock = 1'b0;
    for (int i = 0; i < 4; i++) din[i] = 8'h00;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Full rotation, one result per cycle.
    din[0] = 8'h80; din[1] = 8'h01; din[2] = 8'h10; din[3] = 8'h04;
    step(4'b1111, 1, 0, "rot0");
    chk("rot0.Sdir", 32'(S), 32'd0); chk("rot0.Fdir", 32'(F), 32'd7);
    step(4'b1111, 1, 0, "rot1");
    chk("rot1.Sdir", 32'(S), 32'd1); chk("rot1.Fdir", 32'(F), 32'd0);
    step(4'b1111, 1, 0, "rot2");
    chk("rot2.Sdir", 32'(S), 32'd2); chk("rot2.Fdir", 32'(F), 32'd4);
    step(4'b1111, 1, 0, "rot3");
    chk("rot3.Sdir", 32'(S), 32'd3); chk("rot3.Fdir", 32'(F), 32'd2);
    step(4'b1111, 1, 0, "rot4");
    chk("rot4.Sdir", 32'(S), 32'd0); chk("rot4.ackdir", 32'(ack), 32'h1);
    step(4'b0000, 1, 0, "drain");
    chk("drain.valid", 32'(out_valid), 32'd0);

    // Backpressure: result held, data input changes ignored, single ack.
    din[2] = 8'h0A;
    step(4'b0100, 0, 0, "bp_load");
    chk("bp_load.Fdir", 32'(F), 32'd3); chk("bp_load.ackdir", 32'(ack), 32'h4);
    din[2] = 8'hFF;
    for (int i = 0; i < 5; i++) step(4'b0100, 0, 0, "bp_hold");
    chk("bp_hold.Fdir", 32'(F), 32'd3); chk("bp_hold.ackdir", 32'(ack), 32'h0);
    step(4'b0000, 1, 0, "bp_accept");
    chk("bp_accept.valid", 32'(out_valid), 32'd0);

    // Wraparound: serve channel 2 so the scan starts at 3, then 0 then 1.
    din[0] = 8'h21; din[1] = 8'h02;
    step(4'b0100, 0, 0, "wrap_a");
    step(4'b0011, 1, 0, "wrap_b");
    chk("wrap_b.Sdir", 32'(S), 32'd0);
    step(4'b0011, 1, 0, "wrap_c");
    chk("wrap_c.Sdir", 32'(S), 32'd1);
    step(4'b0000, 1, 0, "wrap_d");

    // Lock holds channel 1, release moves to channel 2.
    step(4'b0010, 0, 0, "lock_a");
    for (int i = 0; i < 3; i++) begin
      step(4'b0110, 1, 1, "lock_b");
      chk("lock_b.Sdir", 32'(S), 32'd1);
    end
    step(4'b0110, 1, 0, "lock_c");
    chk("lock_c.Sdir", 32'(S), 32'd2);
    step(4'b0000, 1, 0, "lock_d");

    // All-zero granted vector.
    din[0] = 8'h00;
    step(4'b0001, 1, 0, "zero_vec");
    chk("zero_vec.Fdir", 32'(F), 32'd0);
    step(4'b0000, 1, 0, "zero_drain");

    // Asynchronous reset while a result is held.
    din[3] = 8'h40;
    step(4'b1000, 0, 0, "rst_load");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111, 0, 0, "rst_first");
    chk("rst_first.Sdir", 32'(S), 32'd0);
    step(4'b0000, 1, 0, "rst_drain");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
      if ($urandom_range(0, 7) == 0) din[$urandom_range(0, 3)] = 8'h00;
      step(($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom),
           bit'($urandom_range(0, 2) != 0),
           bit'($urandom_range(0, 3) == 0),
           "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prio_enc_rr_sched.md
PRIO_ENC_RR_SCHED -- requirements
Module: prio_enc_rr_sched

Interface
REQ-001 SHALL have parameter PTR_INIT, default 0, round-robin pointer value loaded at reset (legal 0..3).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports I0, I1, I2, I3  input  8 each  request data vectors of channels 0..3.
REQ-005 SHALL have port req  input  4  per-channel request, bit k for channel k.
REQ-006 SHALL have port ack  output  4  one-hot one-cycle grant acknowledge.
REQ-007 SHALL have port S  output  2  registered index of the channel whose result is held.
REQ-008 SHALL have port F  output  3  registered priority-encoded code of the granted vector.
REQ-009 SHALL have port out_valid  output  1  F/S hold a result.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port lock  input  1  keep grant on the current S channel while asserted.

Function
REQ-012 SHALL implement states IDLE (no result held) and HOLD (result held, out_valid=1).
REQ-013 SHALL compute winner = first k with req[k]=1 scanning ptr, ptr+1, ... modulo 4 (wrap 3->0).
REQ-014 SHALL encode F = index of highest set bit of the winner's vector (bit 7 highest priority, code 7..0).
REQ-015 SHALL, in IDLE with req!=0, at next edge load S=winner, F=code, out_valid=1, ack[winner]=1, go HOLD.
REQ-016 SHALL, in IDLE with req==0, stay IDLE with out_valid=0, ack=0.
REQ-017 SHALL hold S, F, out_valid stable in HOLD while out_ready=0.
REQ-018 SHALL, in HOLD with out_ready=1 and req!=0, load the next winner in the same edge and stay HOLD (one result per cycle).
REQ-019 SHALL, in HOLD with out_ready=1 and req==0, clear out_valid and go IDLE; S and F retain last values.
REQ-020 SHALL advance ptr to (S+1) mod 4 on every accepted result (HOLD and out_ready=1).
REQ-021 SHALL, when lock=1 and req[S]=1 at an acceptance or IDLE load, grant channel S regardless of ptr and leave ptr unchanged.
REQ-022 SHALL, when lock=1 but req[S]=0, arbitrate normally per REQ-013.
REQ-023 SHALL drive ack as a registered pulse, high exactly one cycle, coincident with the first cycle of the corresponding result.
REQ-024 SHALL sample I[winner] on the loading edge only; later changes to I inputs do not alter a held F.
REQ-025 SHALL keep ack at most one-hot in every cycle.

Reset
REQ-026 SHALL, on rst_n=0, immediately force state=IDLE, ptr=PTR_INIT, S=0, F=0, out_valid=0, ack=0.
REQ-027 SHALL discard any held result on reset mid-HOLD; no ack issued for it after reset release.
REQ-028 SHALL evaluate arbitration on the first rising edge after rst_n deasserts.

Configuration
REQ-029 SHALL support macro PRIO_ENC_ZERO_DETECT_EN.
REQ-030 SHALL, with PRIO_ENC_ZERO_DETECT_EN defined, add output port zero (1 bit, registered, reset 0) set to 1 with F=0 when the granted vector is 8'h00, else 0; zero follows F timing.
REQ-031 SHALL, without PRIO_ENC_ZERO_DETECT_EN, omit port zero; an all-zero granted vector yields F=0 indistinguishable from bit 0 set.

Verification
REQ-032 SHALL cover: reset, req=4'b1111, out_ready=1, I0..I3=8'h80,8'h01,8'h10,8'h04 -> S sequence 0,1,2,3,0 on consecutive cycles, F 7,0,4,2,7, ack 0001,0010,0100,1000,0001.
REQ-033 SHALL cover: req=4'b0100, I2=8'h0A, out_ready=0 for 5 cycles then 1 -> S=2, F=3 stable 5+ cycles, single ack pulse 4'b0100, out_valid drops after acceptance.
REQ-034 SHALL cover: ptr=3, req=4'b0011 -> grant channel 0 (wrap), then channel 1.
REQ-035 SHALL cover: lock=1, S=1, req=4'b0110, out_ready=1 -> channel 1 granted repeatedly; lock=0 -> channel 2 next.
REQ-036 SHALL cover: rst_n pulsed low mid-HOLD with out_ready=0 -> out_valid, ack, S, F go 0 asynchronously; first grant after release follows PTR_INIT.
REQ-037 SHALL cover: granted vector 8'h00 -> F=0 and zero=1 with PRIO_ENC_ZERO_DETECT_EN, F=0 without.
